viewport_coord_gen: RTL and testbench

Upstream stage of the pole/zero pixel pipeline: scans the frame in raster order and emits one signed complex-plane coordinate (re, im) per pixel, with start-of-frame and end-of-line flags, into the complex-subtraction stage. The viewport (top-left origin and per-pixel step) is sampled once per frame so software can pan and zoom without tearing. The stage advances only when downstream `ready` is high, matching the pipeline's global stall.

---
 rtl/coord_pkg.sv | 24 ++
 rtl/coord_sat.sv | 25 ++
 rtl/viewport_coord_gen.sv | 114 +++++++++++
 tb/tb_viewport_coord_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/coord_pkg.sv
// Shared types and sizing helpers for the viewport coordinate generator.
package coord_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } vcg_state_t;

  localparam int COORD_W_DEFAULT = 16;

  // Wide enough that origin + (max(x_size, y_size) - 1) * step cannot overflow.
  function automatic int acc_width(input int x_size, input int y_size, input int coord_w);
    int m;
    int b;
    m = (x_size > y_size) ? x_size : y_size;
    b = 0;
    while ((1 << b) < m) begin
      b = b + 1;
    end
    return coord_w + b + 1;
  endfunction

endpackage

// File: rtl/coord_sat.sv
// Combinational clamp of a wide signed accumulator onto a COORD_W signed output.
module coord_sat #(
  parameter int AW      = 27,
  parameter int COORD_W = 16
) (
  input  logic signed [AW-1:0]      acc,
  output logic signed [COORD_W-1:0] sat
);

  logic [AW-COORD_W:0] top_bits;
  logic                in_range;

  // In range exactly when all bits above the output sign bit match it.
  assign top_bits = acc[AW-1:COORD_W-1];
  assign in_range = (&top_bits) | ~(|top_bits);

  always_comb begin
    sat = acc[COORD_W-1:0];
    if (!in_range) begin
      if (acc[AW-1]) sat = {1'b1, {(COORD_W-1){1'b0}}};
      else           sat = {1'b0, {(COORD_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/viewport_coord_gen.sv
// Raster-order complex-plane coordinate generator with per-frame viewport sampling.
// Define VIEWPORT_COORD_SAT_EN to clamp x/y instead of wrapping.
module viewport_coord_gen
  import coord_pkg::*;
#(
  parameter int X_SIZE  = 640,
  parameter int Y_SIZE  = 480,
  parameter int COORD_W = COORD_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      en,
  input  logic signed [COORD_W-1:0] origin_re,
  input  logic signed [COORD_W-1:0] origin_im,
  input  logic signed [COORD_W-1:0] step,
  input  logic                      ready,
  output logic signed [COORD_W-1:0] x,
  output logic signed [COORD_W-1:0] y,
  output logic                      first,
  output logic                      lastx,
  output logic                      valid,
  output logic                      busy,
  output vcg_state_t                state
);

  localparam int AW = acc_width(X_SIZE, Y_SIZE, COORD_W);
  localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

  // Handshake: a pixel transfers on every clock edge where valid && ready;
  // valid rises only in RUN and never drops until the frame's last transfer.

  vcg_state_t               state_next;
  logic [XW-1:0]            x_cnt;
  logic [YW-1:0]            y_cnt;
  logic signed [AW-1:0]     acc_re;
  logic signed [AW-1:0]     acc_im;
  logic signed [COORD_W-1:0] org_re_s;
  logic signed [COORD_W-1:0] org_im_s;
  logic signed [COORD_W-1:0] step_s;
  logic                     accept;
  logic                     end_line;
  logic                     end_frame;

  function automatic logic signed [AW-1:0] sext(input logic [COORD_W-1:0] v);
    return {{(AW-COORD_W){v[COORD_W-1]}}, v};
  endfunction

  assign accept    = (state == RUN) && ready;
  assign end_line  = (x_cnt == X_LAST);
  assign end_frame = end_line && (y_cnt == Y_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = LOAD;
      LOAD:    state_next = RUN;
      RUN:     if (accept && end_frame) state_next = en ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      acc_re   <= '0;
      acc_im   <= '0;
      org_re_s <= '0;
      org_im_s <= '0;
      step_s   <= '0;
    end else if (state == LOAD) begin
      org_re_s <= origin_re;
      org_im_s <= origin_im;
      step_s   <= step;
      x_cnt    <= '0;
      y_cnt    <= '0;
      acc_re   <= sext(origin_re);
      acc_im   <= sext(origin_im);
    end else if (accept) begin
      if (end_line) begin
        // Imaginary axis decreases down the screen.
        x_cnt  <= '0;
        y_cnt  <= end_frame ? '0 : y_cnt + 1'b1;
        acc_re <= sext(org_re_s);
        acc_im <= acc_im - sext(step_s);
      end else begin
        x_cnt  <= x_cnt + 1'b1;
        acc_re <= acc_re + sext(step_s);
      end
    end
  end

  assign valid = (state == RUN);
  assign busy  = (state != IDLE);
  assign first = valid && (x_cnt == '0) && (y_cnt == '0);
  assign lastx = valid && end_line;

`ifdef VIEWPORT_COORD_SAT_EN
  coord_sat #(.AW(AW), .COORD_W(COORD_W)) u_sat_re (.acc(acc_re), .sat(x));
  coord_sat #(.AW(AW), .COORD_W(COORD_W)) u_sat_im (.acc(acc_im), .sat(y));
`else
  assign x = acc_re[COORD_W-1:0];
  assign y = acc_im[COORD_W-1:0];
`endif

endmodule

// File: tb/tb_viewport_coord_gen.sv
// Scoreboard bench for viewport_coord_gen on a 4x3 frame.
module tb_viewport_coord_gen;
  import coord_pkg::*;

  localparam int W = 34;

  logic              clk;
  logic              resetn;
  logic              en;
  logic signed [15:0] origin_re;
  logic signed [15:0] origin_im;
  logic signed [15:0] step;
  logic              ready;
  logic signed [15:0] x;
  logic signed [15:0] y;
  logic              first;
  logic              lastx;
  logic              valid;
  logic              busy;
  vcg_state_t        state;

  logic [W-1:0] exp_q[$];
  int n_cmp;
  int n_bad;
  int acc_cnt;

  viewport_coord_gen #(.X_SIZE(4), .Y_SIZE(3), .COORD_W(16)) dut (
    .clk(clk), .resetn(resetn), .en(en),
    .origin_re(origin_re), .origin_im(origin_im), .step(step),
    .ready(ready), .x(x), .y(y), .first(first), .lastx(lastx),
    .valid(valid), .busy(busy), .state(state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_out(input int v);
`ifdef VIEWPORT_COORD_SAT_EN
    if (v > 32767)  return 16'h7fff;
    if (v < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  task automatic push_frame(input int ore, input int oim, input int stp, input int npix);
    for (int i = 0; i < npix; i++) begin
      int xi;
      int yi;
      xi = i % 4;
      yi = i / 4;
      exp_q.push_back({to_out(ore + xi * stp), to_out(oim - yi * stp), (i == 0), (xi == 3)});
    end
  endtask

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wait_acc(input int target);
    int k;
    k = 0;
    while (acc_cnt < target && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (acc_cnt < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: accepted %0d, required %0d", acc_cnt, target);
    end
  endtask

  // monitor: pops one expectation per transferred pixel
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (resetn && valid && ready) begin
      acc_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pixel%0d: unexpected x=%0d y=%0d, required none", acc_cnt, x, y);
      end else begin
        e = exp_q.pop_front();
        if ({x, y, first, lastx} !== e) begin
          n_bad++;
          $display("FAIL pixel%0d: got x=%0d y=%0d first=%0b lastx=%0b, required x=%0d y=%0d first=%0b lastx=%0b",
                   acc_cnt, x, y, first, lastx, $signed(e[33:18]), $signed(e[17:2]), e[1], e[0]);
        end
      end
    end
  end

  // driver
  initial begin
    n_cmp = 0; n_bad = 0; acc_cnt = 0;
    resetn = 1'b0; en = 1'b0; ready = 1'b1;
    origin_re = '0; origin_im = '0; step = '0;

    #12;
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_first", first, 0);
    check("rst_lastx", lastx, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state, IDLE);

    @(posedge clk); #1 resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_valid", valid, 0);
    check("idle_busy", busy, 0);

    // raster scan, mid-frame viewport change, stall, back-to-back frames
    origin_re = -100; origin_im = 50; step = 10;
    push_frame(-100, 50, 10, 12);
    push_frame(0, 0, 10, 12);
    en = 1'b1;
    @(posedge clk); #1;
    check("load_valid", valid, 0);
    check("load_busy", busy, 1);
    @(posedge clk); #1;
    check("start_valid", valid, 1);
    check("start_first", first, 1);
    wait_acc(2);
    origin_re = 0; origin_im = 0;
    wait_acc(5);
    ready = 1'b0;
    repeat (5) begin
      check("stall_x", x, -90);
      check("stall_y", y, 40);
      check("stall_valid", valid, 1);
      @(posedge clk); #1;
    end
    ready = 1'b1;
    wait_acc(12);
    check("bubble_valid", valid, 0);
    check("bubble_busy", busy, 1);
    @(posedge clk); #1;
    check("next_valid", valid, 1);
    check("next_first", first, 1);

    // disable mid-frame: frame completes, then idle
    wait_acc(16);
    en = 1'b0;
    wait_acc(24);
    check("dis_valid", valid, 0);
    check("dis_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("dis_hold_valid", valid, 0);
    check("dis_hold_state", state, IDLE);

    // overflow row, then a frame interrupted by reset
    origin_re = 32760; origin_im = 0; step = 5;
    push_frame(32760, 0, 5, 12);
    push_frame(-100, 50, 10, 6);
    en = 1'b1;
    wait_acc(25);
    origin_re = -100; origin_im = 50; step = 10;
    wait_acc(42);
    #1 resetn = 1'b0;
    #1;
    check("arst_valid", valid, 0);
    check("arst_busy", busy, 0);
    check("arst_x", x, 0);
    check("arst_y", y, 0);
    check("arst_first", first, 0);
    @(posedge clk); #1 resetn = 1'b1;
    push_frame(-100, 50, 10, 12);
    @(posedge clk); #1;
    check("rel_load_valid", valid, 0);
    check("rel_load_busy", busy, 1);
    @(posedge clk); #1;
    check("rel_valid", valid, 1);
    check("rel_first", first, 1);
    check("rel_x", x, -100);
    check("rel_y", y, 50);
    en = 1'b0;
    wait_acc(54);
    check("end_valid", valid, 0);
    check("end_busy", busy, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
